gtech_demux2_reg: RTL and testbench

Registered 1-to-2 stream demultiplexer with valid/ready handshakes. It splits one source stream into two destination streams, A and B, under a per-word select. It is the splitting counterpart of the AND-OR merge cells in the GTECH library. It sits between a single producer and two consumers, with one holding register per destination so that each destination's backpressure is isolated from the other. Each destination also has a wrapping transfer counter for debug and verification.

---
 rtl/gtech_demux2_reg.sv | 87 ++++++++
 tb/tb_gtech_demux2_reg.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/gtech_demux2_reg.sv
// Registered 1-to-2 valid/ready stream demultiplexer with one holding slot
// per destination and a wrapping handshake counter on each output.
module gtech_demux2_reg #(
  parameter int WIDTH = 8,
  parameter int CW    = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_SEL,
  output logic             OUTA_VALID,
  input  logic             OUTA_READY,
  output logic [WIDTH-1:0] OUTA_DATA,
  output logic             OUTB_VALID,
  input  logic             OUTB_READY,
  output logic [WIDTH-1:0] OUTB_DATA,
  output logic [CW-1:0]    CNTA,
  output logic [CW-1:0]    CNTB
);

  logic             vld_a_q, vld_a_d, vld_b_q, vld_b_d;
  logic [WIDTH-1:0] dat_a_q, dat_a_d, dat_b_q, dat_b_d;
  logic [CW-1:0]    cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic             drn_a, drn_b, free_a, free_b, acc_a, acc_b, in_ready;

  // A full slot that drains this cycle counts as free, so fill and drain
  // can overlap and each destination sustains one word per cycle.
  always_comb begin
    drn_a    = vld_a_q & OUTA_READY;
    drn_b    = vld_b_q & OUTB_READY;
    free_a   = !vld_a_q | drn_a;
    free_b   = !vld_b_q | drn_b;
    in_ready = IN_SEL ? free_b : free_a;
    acc_a    = IN_VALID & in_ready & !IN_SEL;
    acc_b    = IN_VALID & in_ready & IN_SEL;

    vld_a_d = vld_a_q;
    dat_a_d = dat_a_q;
    if (acc_a) begin
      vld_a_d = 1'b1;
      dat_a_d = IN_DATA;
    end else if (drn_a) begin
      vld_a_d = 1'b0;
    end

    vld_b_d = vld_b_q;
    dat_b_d = dat_b_q;
    if (acc_b) begin
      vld_b_d = 1'b1;
      dat_b_d = IN_DATA;
    end else if (drn_b) begin
      vld_b_d = 1'b0;
    end

    cnt_a_d = cnt_a_q + CW'(drn_a);
    cnt_b_d = cnt_b_q + CW'(drn_b);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_a_q <= 1'b0;
      vld_b_q <= 1'b0;
      dat_a_q <= '0;
      dat_b_q <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      vld_a_q <= vld_a_d;
      vld_b_q <= vld_b_d;
      dat_a_q <= dat_a_d;
      dat_b_q <= dat_b_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign IN_READY   = in_ready;
  assign OUTA_VALID = vld_a_q;
  assign OUTA_DATA  = dat_a_q;
  assign OUTB_VALID = vld_b_q;
  assign OUTB_DATA  = dat_b_q;
  assign CNTA       = cnt_a_q;
  assign CNTB       = cnt_b_q;

endmodule

// File: tb/tb_gtech_demux2_reg.sv
// Directed bench for gtech_demux2_reg: routing, backpressure, throughput,
// counter wrap, simultaneous events and asynchronous reset.
module tb_gtech_demux2_reg;

  logic       CLK = 1'b0;
  logic       RST;
  logic       IN_VALID, IN_READY, IN_SEL;
  logic [7:0] IN_DATA;
  logic       OUTA_VALID, OUTA_READY, OUTB_VALID, OUTB_READY;
  logic [7:0] OUTA_DATA, OUTB_DATA, CNTA, CNTB;

  int checks = 0;
  int errors = 0;

  gtech_demux2_reg #(.WIDTH(8), .CW(8)) dut (
    .CLK(CLK), .RST(RST),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA), .IN_SEL(IN_SEL),
    .OUTA_VALID(OUTA_VALID), .OUTA_READY(OUTA_READY), .OUTA_DATA(OUTA_DATA),
    .OUTB_VALID(OUTB_VALID), .OUTB_READY(OUTB_READY), .OUTB_DATA(OUTB_DATA),
    .CNTA(CNTA), .CNTB(CNTB)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    IN_VALID = 1'b0;
    step();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; IN_VALID = 1'b0; IN_SEL = 1'b0; IN_DATA = '0;
    OUTA_READY = 1'b0; OUTB_READY = 1'b0;
    #2;
    checks++; if ({OUTA_VALID, OUTB_VALID} !== 2'b00) begin errors++; $display("FAIL reset_valid got %b want 00", {OUTA_VALID, OUTB_VALID}); end
    checks++; if ({OUTA_DATA, OUTB_DATA} !== 16'h0000) begin errors++; $display("FAIL reset_data got %h want 0000", {OUTA_DATA, OUTB_DATA}); end
    checks++; if ({CNTA, CNTB} !== 16'h0000) begin errors++; $display("FAIL reset_cnt got %h want 0000", {CNTA, CNTB}); end
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", IN_READY); end
    step(); step();
    RST = 1'b0;
  endtask

  task automatic test_routing();
    OUTA_READY = 1'b1; OUTB_READY = 1'b1;
    IN_VALID = 1'b1; IN_SEL = 1'b0; IN_DATA = 8'h11;
    step();
    checks++; if (OUTA_VALID !== 1'b1 || OUTA_DATA !== 8'h11) begin errors++; $display("FAIL route_a got v=%b d=%h want v=1 d=11", OUTA_VALID, OUTA_DATA); end
    IN_SEL = 1'b1; IN_DATA = 8'h22;
    step();
    IN_VALID = 1'b0;
    checks++; if (OUTA_VALID !== 1'b0 || CNTA !== 8'd1) begin errors++; $display("FAIL route_a_drain got v=%b cnt=%0d want v=0 cnt=1", OUTA_VALID, CNTA); end
    checks++; if (OUTB_VALID !== 1'b1 || OUTB_DATA !== 8'h22) begin errors++; $display("FAIL route_b got v=%b d=%h want v=1 d=22", OUTB_VALID, OUTB_DATA); end
    step();
    checks++; if (OUTB_VALID !== 1'b0 || CNTB !== 8'd1) begin errors++; $display("FAIL route_b_drain got v=%b cnt=%0d want v=0 cnt=1", OUTB_VALID, CNTB); end
  endtask

  task automatic test_isolation();
    OUTA_READY = 1'b0; OUTB_READY = 1'b1;
    IN_VALID = 1'b1; IN_SEL = 1'b0; IN_DATA = 8'h33;
    step();
    IN_DATA = 8'h99;
    #1;
    checks++; if (IN_READY !== 1'b0) begin errors++; $display("FAIL iso_blocked got %b want 0", IN_READY); end
    step();
    checks++; if (OUTA_VALID !== 1'b1 || OUTA_DATA !== 8'h33 || CNTA !== 8'd1) begin errors++; $display("FAIL iso_a_hold got v=%b d=%h cnt=%0d want v=1 d=33 cnt=1", OUTA_VALID, OUTA_DATA, CNTA); end
    IN_SEL = 1'b1;
    for (int i = 0; i < 4; i++) begin
      IN_DATA = 8'h40 + 8'(i);
      #1;
      checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL iso_b_ready[%0d] got %b want 1", i, IN_READY); end
      step();
      checks++; if (OUTB_DATA !== 8'h40 + 8'(i)) begin errors++; $display("FAIL iso_b_data[%0d] got %h want %h", i, OUTB_DATA, 8'h40 + 8'(i)); end
    end
    IN_VALID = 1'b0;
    step();
    checks++; if (CNTB !== 8'd5 || OUTB_VALID !== 1'b0) begin errors++; $display("FAIL iso_cntb got cnt=%0d v=%b want cnt=5 v=0", CNTB, OUTB_VALID); end
    checks++; if (OUTA_VALID !== 1'b1 || OUTA_DATA !== 8'h33) begin errors++; $display("FAIL iso_a_stable got v=%b d=%h want v=1 d=33", OUTA_VALID, OUTA_DATA); end
    OUTA_READY = 1'b1;
    step();
    checks++; if (OUTA_VALID !== 1'b0 || CNTA !== 8'd2) begin errors++; $display("FAIL iso_a_release got v=%b cnt=%0d want v=0 cnt=2", OUTA_VALID, CNTA); end
  endtask

  task automatic test_throughput();
    OUTA_READY = 1'b1;
    IN_VALID = 1'b1; IN_SEL = 1'b0;
    for (int i = 0; i < 16; i++) begin
      IN_DATA = 8'h80 + 8'(i);
      #1;
      checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL thr_ready[%0d] got %b want 1", i, IN_READY); end
      step();
      checks++; if (OUTA_VALID !== 1'b1 || OUTA_DATA !== 8'h80 + 8'(i)) begin errors++; $display("FAIL thr_out[%0d] got v=%b d=%h want v=1 d=%h", i, OUTA_VALID, OUTA_DATA, 8'h80 + 8'(i)); end
    end
    IN_VALID = 1'b0;
    step();
    checks++; if (CNTA !== 8'd18 || OUTA_VALID !== 1'b0) begin errors++; $display("FAIL thr_cnta got cnt=%0d v=%b want cnt=18 v=0", CNTA, OUTA_VALID); end
  endtask

  task automatic test_wrap();
    do_reset();
    OUTA_READY = 1'b1; OUTB_READY = 1'b1;
    IN_VALID = 1'b1; IN_SEL = 1'b1; IN_DATA = 8'h01;
    step();
    IN_SEL = 1'b0;
    for (int i = 0; i < 256; i++) begin
      IN_DATA = 8'(i);
      step();
    end
    IN_VALID = 1'b0;
    checks++; if (CNTA !== 8'd255) begin errors++; $display("FAIL wrap_255 got %0d want 255", CNTA); end
    step();
    checks++; if (CNTA !== 8'd0) begin errors++; $display("FAIL wrap_256 got %0d want 0", CNTA); end
    IN_VALID = 1'b1; IN_DATA = 8'hEE;
    step();
    IN_VALID = 1'b0;
    step();
    checks++; if (CNTA !== 8'd1) begin errors++; $display("FAIL wrap_257 got %0d want 1", CNTA); end
    checks++; if (CNTB !== 8'd1) begin errors++; $display("FAIL wrap_cntb got %0d want 1", CNTB); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    OUTA_READY = 1'b0; OUTB_READY = 1'b0;
    IN_VALID = 1'b1; IN_SEL = 1'b0; IN_DATA = 8'h5A;
    step();
    IN_SEL = 1'b1; IN_DATA = 8'hA5;
    step();
    checks++; if ({OUTA_VALID, OUTB_VALID} !== 2'b11 || {OUTA_DATA, OUTB_DATA} !== 16'h5AA5) begin errors++; $display("FAIL sim_fill got v=%b d=%h want v=11 d=5aa5", {OUTA_VALID, OUTB_VALID}, {OUTA_DATA, OUTB_DATA}); end
    IN_DATA = 8'hC3;
    #1;
    checks++; if (IN_READY !== 1'b0) begin errors++; $display("FAIL sim_full_stall got %b want 0", IN_READY); end
    OUTA_READY = 1'b1; OUTB_READY = 1'b1;
    #1;
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL sim_full_drain_ready got %b want 1", IN_READY); end
    step();
    IN_VALID = 1'b0;
    checks++; if (CNTA !== 8'd1 || CNTB !== 8'd1) begin errors++; $display("FAIL sim_cnt got a=%0d b=%0d want a=1 b=1", CNTA, CNTB); end
    checks++; if (OUTA_VALID !== 1'b0 || OUTB_VALID !== 1'b1 || OUTB_DATA !== 8'hC3) begin errors++; $display("FAIL sim_slots got va=%b vb=%b db=%h want va=0 vb=1 db=c3", OUTA_VALID, OUTB_VALID, OUTB_DATA); end
  endtask

  task automatic test_reset_mid();
    OUTA_READY = 1'b0; OUTB_READY = 1'b0;
    IN_VALID = 1'b1; IN_SEL = 1'b0; IN_DATA = 8'h5A;
    step();
    IN_SEL = 1'b0; IN_DATA = 8'h77;
    #1;
    checks++; if (IN_READY !== 1'b0 || OUTA_DATA !== 8'h5A || OUTB_DATA !== 8'hC3) begin errors++; $display("FAIL mid_prefill got rdy=%b a=%h b=%h want rdy=0 a=5a b=c3", IN_READY, OUTA_DATA, OUTB_DATA); end
    #1;
    RST = 1'b1;
    #1;
    checks++; if ({OUTA_VALID, OUTB_VALID} !== 2'b00 || {OUTA_DATA, OUTB_DATA} !== 16'h0000) begin errors++; $display("FAIL mid_clear got v=%b d=%h want v=00 d=0000", {OUTA_VALID, OUTB_VALID}, {OUTA_DATA, OUTB_DATA}); end
    checks++; if ({CNTA, CNTB} !== 16'h0000 || IN_READY !== 1'b1) begin errors++; $display("FAIL mid_cnt_ready got cnt=%h rdy=%b want cnt=0000 rdy=1", {CNTA, CNTB}, IN_READY); end
    step();
    checks++; if (OUTA_VALID !== 1'b0) begin errors++; $display("FAIL mid_accept_ignored got %b want 0", OUTA_VALID); end
    RST = 1'b0;
    IN_DATA = 8'h12;
    step();
    IN_VALID = 1'b0;
    checks++; if (OUTA_VALID !== 1'b1 || OUTA_DATA !== 8'h12 || CNTA !== 8'd0) begin errors++; $display("FAIL mid_restart got v=%b d=%h cnt=%0d want v=1 d=12 cnt=0", OUTA_VALID, OUTA_DATA, CNTA); end
  endtask

  initial begin
    test_reset();
    test_routing();
    test_isolation();
    test_throughput();
    test_wrap();
    test_simultaneous();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
